accum_frame_ctrl: RTL and testbench
===================================

# accum_frame_ctrl

Frame controller that sits directly upstream of the 16-bit feedback accumulator. It accepts samples over a valid/ready stream and buffers them in a small FIFO. It feeds exactly FRAME_LEN samples into the accumulator's `in`, then captures the accumulator's `out` as a frame result, clears the accumulator through its reset, and presents the result downstream with a sticky wrap-around (overflow) flag.

## Interface
Parameters:
- WIDTH, 16, sample, accumulator and result width
- DEPTH, 4, input FIFO entries (power of two, ≥2)
- FRAME_LEN, 8, samples per frame (≥1)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- s_valid  in  1  input sample valid
- s_ready  out  1  input ready = FIFO not full and not reset
- s_data  in  WIDTH  input sample
- acc_in  out  WIDTH  drives accumulator `in`; 0 when not popping
- acc_clear  out  1  drives accumulator `reset`
- acc_out  in  WIDTH  accumulator `out` (registered running sum)
- m_valid  out  1  frame result valid
- m_ready  in  1  downstream accepts result
- m_data  out  WIDTH  frame sum, modulo 2^WIDTH
- m_overflow  out  1  at least one carry-out occurred during the frame

## Operation
- Reset: FIFO empty, state FEED, count 0, sticky ovf 0, m_valid 0, m_data 0, m_overflow 0, acc_in 0, s_ready 0, acc_clear 1 (acc_clear = reset OR dump_fire).
- Push: s_valid && s_ready at an edge writes s_data to the FIFO. There is no empty bypass. s_ready depends only on full, so a full FIFO refuses a push even when a pop occurs in the same cycle.
- State FEED: pop = FIFO not empty.
  - On pop, acc_in = head; otherwise acc_in = 0.
  - On pop: count++, and ovf |= carry-out of (acc_out + head) at WIDTH+1 bits.
  - A pop with count == FRAME_LEN-1 sets count to 0 and moves to DUMP.
- State DUMP: no pop and acc_in = 0. At this point acc_out holds the full frame sum.
  - dump_fire = !m_valid || m_ready.
  - When dump_fire is high: m_data ← acc_out, m_overflow ← ovf, m_valid ← 1, ovf ← 0, acc_clear = 1 (the accumulator reads 0 next cycle), next state FEED.
  - When dump_fire is low: stay in DUMP and hold everything. Pushes continue until the FIFO is full.
- Output: m_valid && m_ready with no dump_fire clears m_valid. A simultaneous accept and dump_fire keeps m_valid at 1 and loads the new result.
- Arithmetic: the sum wraps modulo 2^WIDTH, matching the accumulator. m_overflow is set if the unsigned sum across the frame exceeds 2^WIDTH-1.
- Reset mid-frame: partial count, FIFO contents, ovf and any pending result are discarded. The accumulator is cleared by acc_clear.

## Timing
- Sample accepted at edge t with the FIFO empty → earliest pop at edge t+1.
- Last sample of a frame accepted at edge t (FIFO empty, output free) → DUMP in cycle t+1..t+2 → m_valid high from edge t+2.
- Throughput: FRAME_LEN samples per FRAME_LEN+1 cycles, since there is one DUMP bubble per frame.
- acc_in and acc_clear are combinational from state and FIFO head. The accumulator samples them at the same edge as the pop or dump.
- acc_out is only read in the cycle it is valid. It is never latched before DUMP.
- FRAME_LEN = 1: FEED and DUMP alternate every cycle.

## Structure
- Package accum_frame_pkg holds the state enum {FEED, DUMP}, the default WIDTH, and a clog2-based count width constant.
- Sub-module accum_feed_fifo: synchronous FIFO (WIDTH × DEPTH) with push, pop, head, full and empty. It has no internal bypass.
- The top level holds the state register, frame counter, carry/ovf logic, output register and handshakes.
- The accumulator is instantiated beside this block, not inside it.

## Test plan
All scenarios run with the real accumulator connected, FRAME_LEN=4, DEPTH=4.
- Samples 1,2,3,4 back-to-back, m_ready=1 → m_data=10, m_overflow=0, m_valid for 1 cycle 2 cycles after the last accept, accumulator reads 0 afterward.
- Samples 0xFFFF,0x0002,0,0 → m_data=0x0001, m_overflow=1. The next frame 1,1,1,1 → m_data=4, m_overflow=0 (sticky flag cleared).
- m_ready=0 with 12 samples streamed → frame 1 held in the output register, frame 2 stalls in DUMP with acc_in=0, FIFO fills and s_ready drops. Release m_ready → results 1..4 sum, then 5..8, then 9..12 in order, with no sample lost.
- Sparse s_valid (random gaps of 0–3 cycles) with values 7,8,9,10 → m_data=34. acc_in=0 on every non-pop cycle.
- Reset for 1 cycle after 2 samples of a frame → acc_clear=1, m_valid=0, s_ready=0 during reset. Afterward, samples 5,5,5,5 → m_data=20.
- Full FIFO plus s_valid held high with a pop in the same cycle → no push that cycle. FIFO count and data ordering are preserved.

Source files
------------

// File: rtl/accum_frame_pkg.sv
// Shared types and sizing helpers for the accumulator frame controller.
package accum_frame_pkg;

  typedef enum logic {FEED, DUMP} state_t;

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_FRAME_LEN = 8;

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_FRAME_LEN);

endpackage

// File: rtl/accum_frame_ctrl_if.sv
// Bundle of the sample stream, accumulator drive/readback and result stream.
interface accum_frame_ctrl_if #(parameter int WIDTH = accum_frame_pkg::DEF_WIDTH);

  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic [WIDTH-1:0] acc_in;
  logic             acc_clear;
  logic [WIDTH-1:0] acc_out;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_overflow;

  // The controller is the slave side; the surrounding system is the master.
  modport slave (
    input  s_valid, s_data, acc_out, m_ready,
    output s_ready, acc_in, acc_clear, m_valid, m_data, m_overflow
  );

  modport master (
    output s_valid, s_data, acc_out, m_ready,
    input  s_ready, acc_in, acc_clear, m_valid, m_data, m_overflow
  );

endinterface

// File: rtl/accum_feed_fifo.sv
// Synchronous FIFO feeding the accumulator; head is the oldest entry, no bypass.
module accum_feed_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/accum_frame_ctrl.sv
// Feeds FRAME_LEN buffered samples into an external accumulator, then captures
// its sum with a sticky carry flag and clears it; one DUMP bubble per frame.
module accum_frame_ctrl
  import accum_frame_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = 4,
  parameter int FRAME_LEN = DEF_FRAME_LEN
) (
  input  logic                 clk,
  input  logic                 reset,
  accum_frame_ctrl_if.slave    bus
);

  localparam int CW = cnt_width(FRAME_LEN);

  state_t           state_q, state_d;
  logic [CW-1:0]    count;
  logic             ovf;
  logic             m_valid_q;
  logic [WIDTH-1:0] m_data_q;
  logic             m_ovf_q;

  logic             push, pop, dump_fire, last;
  logic             full, empty;
  logic [WIDTH-1:0] head;
  logic [WIDTH:0]   sum_wide;

  accum_feed_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (bus.s_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  assign bus.s_ready    = !full && !reset;
  assign push           = bus.s_valid && bus.s_ready;
  assign last           = (count == CW'(FRAME_LEN - 1));
  assign sum_wide       = {1'b0, bus.acc_out} + {1'b0, head};
  assign bus.acc_in     = pop ? head : '0;
  assign bus.acc_clear  = reset || dump_fire;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_data     = m_data_q;
  assign bus.m_overflow = m_ovf_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FEED;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    dump_fire = 1'b0;
    case (state_q)
      FEED: begin
        pop = !empty;
        if (pop && last) state_d = DUMP;
      end
      DUMP: begin
        // acc_out now holds the complete frame sum; wait for the output slot.
        dump_fire = !m_valid_q || bus.m_ready;
        if (dump_fire) state_d = FEED;
      end
      default: state_d = FEED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      ovf       <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_ovf_q   <= 1'b0;
    end else begin
      if (pop) begin
        count <= last ? '0 : count + CW'(1);
        ovf   <= ovf | sum_wide[WIDTH];
      end
      if (dump_fire) begin
        m_data_q  <= bus.acc_out;
        m_ovf_q   <= ovf;
        m_valid_q <= 1'b1;
        ovf       <= 1'b0;
      end else if (m_valid_q && bus.m_ready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_accum_frame_ctrl.sv
// Bench for accum_frame_ctrl with a behavioural accumulator and frame-sum model.
module tb_accum_frame_ctrl;

  localparam int W  = 16;
  localparam int FL = 4;
  localparam int DP = 4;

  typedef struct {
    logic [W-1:0] d;
    logic         o;
  } res_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  accum_frame_ctrl_if #(.WIDTH(W)) bus ();

  accum_frame_ctrl #(.WIDTH(W), .DEPTH(DP), .FRAME_LEN(FL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Registered-sum accumulator with synchronous clear, as sits beside the DUT.
  logic [W-1:0] acc_q;
  always @(posedge clk) acc_q <= bus.acc_clear ? '0 : acc_q + bus.acc_in;
  assign bus.acc_out = acc_q;

  logic m_rdy_dir = 1'b1;
  logic rand_rdy  = 1'b0;
  logic r_bit     = 1'b1;
  always @(posedge clk) r_bit <= 1'($urandom_range(0, 1));
  assign bus.m_ready = rand_rdy ? r_bit : m_rdy_dir;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] feed_q[$];
  logic [W-1:0] frame_q[$];
  res_t         exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected frame results come from plain sums of every group of FL accepted samples.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.acc_in != '0) begin
        while (feed_q.size() > 0 && feed_q[0] == '0) void'(feed_q.pop_front());
        if (feed_q.size() == 0) chk("acc_in_unexpected", 32'(bus.acc_in), 32'h0);
        else                    chk("acc_in_order", 32'(bus.acc_in), 32'(feed_q.pop_front()));
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_result: got 0x%0h expected no result at %0t", bus.m_data, $time);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          chk("m_data", 32'(bus.m_data), 32'(e.d));
          chk("m_overflow", 32'(bus.m_overflow), 32'(e.o));
        end
      end
      if (bus.s_valid && bus.s_ready) begin
        feed_q.push_back(bus.s_data);
        frame_q.push_back(bus.s_data);
        if (frame_q.size() == FL) begin
          int unsigned s;
          res_t r;
          s = 0;
          foreach (frame_q[i]) s += frame_q[i];
          r.d = s[W-1:0];
          r.o = (s > 32'hFFFF);
          exp_q.push_back(r);
          frame_q.delete();
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] v);
    int n;
    bus.s_valid = 1'b1;
    bus.s_data  = v;
    n = 0;
    while (!bus.s_ready && n < 200) begin
      cyc();
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got s_ready=0 expected s_ready=1 within 200 cycles");
    end
    cyc();
  endtask

  task automatic wait_result(output logic [W-1:0] d, output logic o);
    int n;
    n = 0;
    d = 'x;
    o = 1'bx;
    while (!bus.m_valid && n < 50) begin
      cyc();
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL result_timeout: got m_valid=0 expected m_valid=1 within 50 cycles");
    end else begin
      d = bus.m_data;
      o = bus.m_overflow;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      cyc();
      n++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'h0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    feed_q.delete();
    frame_q.delete();
    exp_q.delete();
  endtask

  logic [W-1:0] rd;
  logic         ro;

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    apply_reset();
    cyc();
    cyc();
    chk("rst_m_valid", 32'(bus.m_valid), 32'h0);
    chk("rst_m_data", 32'(bus.m_data), 32'h0);
    chk("rst_m_overflow", 32'(bus.m_overflow), 32'h0);
    chk("rst_acc_in", 32'(bus.acc_in), 32'h0);
    chk("rst_s_ready", 32'(bus.s_ready), 32'h0);
    chk("rst_acc_clear", 32'(bus.acc_clear), 32'h1);
    reset = 1'b0;
    #1;
    chk("post_rst_s_ready", 32'(bus.s_ready), 32'h1);

    // Back-to-back 1..4: DUMP one cycle after the last accept, result the next.
    send(16'd1); send(16'd2); send(16'd3); send(16'd4);
    bus.s_valid = 1'b0;
    cyc();
    chk("b2b_dump_m_valid", 32'(bus.m_valid), 32'h0);
    chk("b2b_dump_acc_out", 32'(bus.acc_out), 32'd10);
    chk("b2b_dump_acc_in", 32'(bus.acc_in), 32'h0);
    cyc();
    chk("b2b_m_valid", 32'(bus.m_valid), 32'h1);
    chk("b2b_m_data", 32'(bus.m_data), 32'd10);
    chk("b2b_m_overflow", 32'(bus.m_overflow), 32'h0);
    chk("b2b_acc_cleared", 32'(bus.acc_out), 32'h0);
    cyc();
    chk("b2b_m_valid_drop", 32'(bus.m_valid), 32'h0);

    // Wrap-around sets the sticky flag; the following frame starts clean.
    send(16'hFFFF); send(16'h0002); send(16'h0000); send(16'h0000);
    bus.s_valid = 1'b0;
    wait_result(rd, ro);
    chk("wrap_m_data", 32'(rd), 32'h1);
    chk("wrap_m_overflow", 32'(ro), 32'h1);
    send(16'd1); send(16'd1); send(16'd1); send(16'd1);
    bus.s_valid = 1'b0;
    wait_result(rd, ro);
    chk("clean_m_data", 32'(rd), 32'd4);
    chk("clean_m_overflow", 32'(ro), 32'h0);
    cyc();

    // Output stall: frame 1 held, frame 2 parked in DUMP, FIFO holds 9..12.
    m_rdy_dir = 1'b0;
    for (int i = 1; i <= 12; i++) send(W'(i));
    bus.s_valid = 1'b0;
    repeat (3) cyc();
    chk("stall_s_ready", 32'(bus.s_ready), 32'h0);
    chk("stall_acc_in", 32'(bus.acc_in), 32'h0);
    chk("stall_acc_clear", 32'(bus.acc_clear), 32'h0);
    chk("stall_m_valid", 32'(bus.m_valid), 32'h1);
    chk("stall_m_data", 32'(bus.m_data), 32'd10);
    chk("stall_acc_out", 32'(bus.acc_out), 32'd26);
    bus.s_valid = 1'b1;
    bus.s_data  = 16'd13;
    m_rdy_dir   = 1'b1;
    cyc();
    chk("full_pop_s_ready", 32'(bus.s_ready), 32'h0);
    chk("full_pop_acc_in", 32'(bus.acc_in), 32'd9);
    chk("reload_m_data", 32'(bus.m_data), 32'd26);
    send(16'd13); send(16'd14); send(16'd15); send(16'd16);
    bus.s_valid = 1'b0;
    drain();

    // Sparse arrivals with random idle gaps.
    for (int i = 0; i < 4; i++) begin
      bus.s_valid = 1'b0;
      repeat ($urandom_range(0, 3)) cyc();
      send(W'(7 + i));
    end
    bus.s_valid = 1'b0;
    wait_result(rd, ro);
    chk("sparse_m_data", 32'(rd), 32'd34);
    chk("sparse_m_overflow", 32'(ro), 32'h0);
    cyc();

    // Reset in the middle of a frame discards the partial frame.
    send(16'd3); send(16'd3);
    bus.s_valid = 1'b0;
    apply_reset();
    #1;
    chk("mid_rst_s_ready", 32'(bus.s_ready), 32'h0);
    chk("mid_rst_acc_clear", 32'(bus.acc_clear), 32'h1);
    cyc();
    chk("mid_rst_m_valid", 32'(bus.m_valid), 32'h0);
    chk("mid_rst_acc_out", 32'(bus.acc_out), 32'h0);
    reset = 1'b0;
    send(16'd5); send(16'd5); send(16'd5); send(16'd5);
    bus.s_valid = 1'b0;
    wait_result(rd, ro);
    chk("after_rst_m_data", 32'(rd), 32'd20);
    chk("after_rst_m_overflow", 32'(ro), 32'h0);
    cyc();

    // Random values, gaps and downstream backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 48; i++) begin
      bus.s_valid = 1'b0;
      repeat ($urandom_range(0, 2)) cyc();
      if ($urandom_range(0, 3) == 0) send(W'($urandom_range(0, 15)));
      else                           send(W'($urandom_range(16'h4000, 16'hFFFF)));
    end
    bus.s_valid = 1'b0;
    drain();
    rand_rdy = 1'b0;
    repeat (3) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
